// File: rtl/imm_pkg.sv
// Shared types and constants for the ID-stage immediate generator.
package imm_pkg;

    // Immediate format select as driven by the decoder.
    typedef enum logic [2:0] {
        IMM_I   = 3'd0,
        IMM_LD  = 3'd1,
        IMM_S   = 3'd2,
        IMM_B   = 3'd3,
        IMM_J   = 3'd4,
        IMM_U   = 3'd5,
        IMM_CSR = 3'd6,
        IMM_RSV = 3'd7
    } imm_sel_e;

    // Supported datapath widths.
    localparam int XLEN_32 = 32;
    localparam int XLEN_64 = 64;

    // True when the datapath width is one the generator supports.
    function automatic logic xlen_legal(input int xlen);
        return (xlen == XLEN_32) || (xlen == XLEN_64);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate format mux. Every format fits in a signed 32-bit
// value (CSR uimm has bit 31 clear), so one sign-extension to XLEN covers all.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [2:0]      sel,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    logic signed [31:0] narrow_s;
    logic               unused_opcode_s;

    // Opcode bits never feed an immediate.
    assign unused_opcode_s = ^inst[6:0];

    // Select the 32-bit immediate for the requested format.
    always_comb begin
        narrow_s = 32'sd0;
        err      = 1'b0;
        case (imm_sel_e'(sel))
            IMM_I, IMM_LD: narrow_s = {{20{inst[31]}}, inst[31:20]};
            IMM_S:         narrow_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:         narrow_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_J:         narrow_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_U:         narrow_s = {inst[31:12], 12'd0};
            IMM_CSR:       narrow_s = {27'd0, inst[19:15]};
            default: begin
                narrow_s = 32'sd0;
                err      = 1'b1;
            end
        endcase
    end

    // Signed size cast extends bit 31 up to the datapath width.
    assign imm = XLEN'(narrow_s);

endmodule

// File: rtl/imm_gen_pipe_chk.sv
// Elaboration-time sanity check on the generator parameters.
module imm_gen_pipe_chk
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) ();

    generate
        if (!xlen_legal(XLEN)) begin : g_xlen_bad
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

endmodule

// File: rtl/imm_gen_pipe.sv
// ID-stage immediate generator: decodes on the input side and carries the
// result plus its tag through a 2-entry FIFO skid buffer with valid/ready.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [2:0]       ImmSel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             imm_err
);

    imm_gen_pipe_chk #(.XLEN(XLEN)) u_chk ();

    logic [XLEN-1:0]  dec_imm_s;
    logic             dec_err_s;

    // Head entry drives the outputs directly; skid holds the second entry.
    logic [XLEN-1:0]  head_imm_r;
    logic [TAG_W-1:0] head_tag_r;
    logic             head_err_r;
    logic [XLEN-1:0]  skid_imm_r;
    logic [TAG_W-1:0] skid_tag_r;
    logic             skid_err_r;

    logic [1:0]       count_r;
    logic [1:0]       count_nxt_s;
    logic             in_ready_r;
    logic             out_valid_r;

    logic             push_s;
    logic             pop_s;
    logic             head_from_dec_s;
    logic             head_from_skid_s;
    logic             skid_from_dec_s;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst (inst),
        .sel  (ImmSel),
        .imm  (dec_imm_s),
        .err  (dec_err_s)
    );

    assign push_s = in_valid & in_ready_r;
    assign pop_s  = out_valid_r & out_ready;

    // Work out the next occupancy and which buffer slots load this cycle.
    always_comb begin
        count_nxt_s      = count_r;
        head_from_dec_s  = 1'b0;
        head_from_skid_s = 1'b0;
        skid_from_dec_s  = 1'b0;
        case ({push_s, pop_s})
            2'b10: begin
                if (count_r == 2'd0) begin
                    head_from_dec_s = 1'b1;
                    count_nxt_s     = 2'd1;
                end else begin
                    skid_from_dec_s = 1'b1;
                    count_nxt_s     = 2'd2;
                end
            end
            2'b01: begin
                if (count_r == 2'd2) begin
                    head_from_skid_s = 1'b1;
                    count_nxt_s      = 2'd1;
                end else begin
                    count_nxt_s      = 2'd0;
                end
            end
            2'b11: begin
                // Push only possible below full and pop only when non-empty,
                // so this is count 1: the new entry replaces the departing head.
                head_from_dec_s = 1'b1;
                count_nxt_s     = count_r;
            end
            default: begin
                count_nxt_s = count_r;
            end
        endcase
    end

    // Buffer state, handshake flags and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r     <= 2'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            head_imm_r  <= '0;
            head_tag_r  <= '0;
            head_err_r  <= 1'b0;
            skid_imm_r  <= '0;
            skid_tag_r  <= '0;
            skid_err_r  <= 1'b0;
        end else if (flush) begin
            count_r     <= 2'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            in_ready_r  <= (count_nxt_s < 2'd2);
            out_valid_r <= (count_nxt_s != 2'd0);
            if (head_from_dec_s) begin
                head_imm_r <= dec_imm_s;
                head_tag_r <= in_tag;
                head_err_r <= dec_err_s;
            end else if (head_from_skid_s) begin
                head_imm_r <= skid_imm_r;
                head_tag_r <= skid_tag_r;
                head_err_r <= skid_err_r;
            end else begin
                head_imm_r <= head_imm_r;
                head_tag_r <= head_tag_r;
                head_err_r <= head_err_r;
            end
            if (skid_from_dec_s) begin
                skid_imm_r <= dec_imm_s;
                skid_tag_r <= in_tag;
                skid_err_r <= dec_err_s;
            end else begin
                skid_imm_r <= skid_imm_r;
                skid_tag_r <= skid_tag_r;
                skid_err_r <= skid_err_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign imm       = head_imm_r;
    assign out_tag   = head_tag_r;
    assign imm_err   = head_err_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 64-bit and a 32-bit instance share the
// same stimulus; format vectors are table-driven, handshake cases hand-written.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] inst;
    logic [2:0]  sel;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready64, out_valid64, err64;
    logic [63:0] imm64;
    logic [31:0] tag64;
    logic        in_ready32, out_valid32, err32;
    logic [31:0] imm32;
    logic [31:0] tag32;

    int pass_cnt;
    int total_cnt;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  sel;
        logic [63:0] e64;
        logic [31:0] e32;
        logic        err;
    } vec_t;

    vec_t vt[12];

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .inst(inst), .ImmSel(sel), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .imm(imm64), .out_tag(tag64), .imm_err(err64)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .inst(inst), .ImmSel(sel), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .imm(imm32), .out_tag(tag32), .imm_err(err32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // I-type instruction whose immediate equals the (12-bit) tag value.
    task automatic drive_tagged(input logic [31:0] t);
        in_valid = 1'b1;
        in_tag   = t;
        sel      = 3'd0;
        inst     = {t[11:0], 20'h00013};
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        vt[0]  = '{32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        vt[1]  = '{32'h7FF00093, 3'd0, 64'h00000000000007FF, 32'h000007FF, 1'b0};
        vt[2]  = '{32'h03F09093, 3'd0, 64'h000000000000003F, 32'h0000003F, 1'b0};
        vt[3]  = '{32'h80012083, 3'd1, 64'hFFFFFFFFFFFFF800, 32'hFFFFF800, 1'b0};
        vt[4]  = '{32'h00A12223, 3'd2, 64'h0000000000000004, 32'h00000004, 1'b0};
        vt[5]  = '{32'hFE000EE3, 3'd3, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 1'b0};
        vt[6]  = '{32'hFE000E63, 3'd3, 64'hFFFFFFFFFFFFF7FC, 32'hFFFFF7FC, 1'b0};
        vt[7]  = '{32'h8000006F, 3'd4, 64'hFFFFFFFFFFF00000, 32'hFFF00000, 1'b0};
        vt[8]  = '{32'h800000B7, 3'd5, 64'hFFFFFFFF80000000, 32'h80000000, 1'b0};
        vt[9]  = '{32'h12345037, 3'd5, 64'h0000000012345000, 32'h12345000, 1'b0};
        vt[10] = '{32'h000FD073, 3'd6, 64'h000000000000001F, 32'h0000001F, 1'b0};
        vt[11] = '{32'hFFFFFFFF, 3'd7, 64'h0000000000000000, 32'h00000000, 1'b1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; inst = 32'd0;
        sel = 3'd0; in_tag = 32'd0; out_ready = 1'b1;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", {63'd0, out_valid64}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready64},  64'd1);
        chk("rst_imm64",     imm64, 64'd0);
        chk("rst_imm32",     {32'd0, imm32}, 64'd0);
        chk("rst_tag",       {32'd0, tag64}, 64'd0);
        chk("rst_err",       {63'd0, err64}, 64'd0);

        // Format table, streamed back to back with out_ready=1 (count stays 1)
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            inst     = vt[i].inst;
            sel      = vt[i].sel;
            in_tag   = 32'h100 + 32'(i * 4);
            tick();
            chk($sformatf("v%0d_valid64", i), {63'd0, out_valid64}, 64'd1);
            chk($sformatf("v%0d_valid32", i), {63'd0, out_valid32}, 64'd1);
            chk($sformatf("v%0d_imm64", i), imm64, vt[i].e64);
            chk($sformatf("v%0d_imm32", i), {32'd0, imm32}, {32'd0, vt[i].e32});
            chk($sformatf("v%0d_err64", i), {63'd0, err64}, {63'd0, vt[i].err});
            chk($sformatf("v%0d_err32", i), {63'd0, err32}, {63'd0, vt[i].err});
            chk($sformatf("v%0d_tag", i), {32'd0, tag64}, {32'd0, 32'h100 + 32'(i * 4)});
            chk($sformatf("v%0d_in_ready", i), {63'd0, in_ready64}, 64'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("drain_valid", {63'd0, out_valid64}, 64'd0);

        // Backpressure: three pushes into a stalled buffer
        out_ready = 1'b0;
        drive_tagged(32'd1);
        tick();
        chk("bp1_in_ready", {63'd0, in_ready64}, 64'd1);
        chk("bp1_tag", {32'd0, tag64}, 64'd1);
        drive_tagged(32'd2);
        tick();
        chk("bp2_in_ready", {63'd0, in_ready64}, 64'd0);
        chk("bp2_tag", {32'd0, tag64}, 64'd1);
        drive_tagged(32'd3);
        tick();
        tick();
        chk("bp3_in_ready", {63'd0, in_ready64}, 64'd0);
        chk("bp3_valid", {63'd0, out_valid64}, 64'd1);
        chk("bp3_tag_held", {32'd0, tag64}, 64'd1);
        chk("bp3_imm_held", imm64, 64'd1);
        out_ready = 1'b1;
        tick();
        chk("bp4_tag", {32'd0, tag64}, 64'd2);
        chk("bp4_imm", imm64, 64'd2);
        chk("bp4_in_ready", {63'd0, in_ready64}, 64'd1);
        tick();
        chk("bp5_tag", {32'd0, tag64}, 64'd3);
        chk("bp5_valid", {63'd0, out_valid64}, 64'd1);
        in_valid = 1'b0;
        tick();
        chk("bp6_empty", {63'd0, out_valid64}, 64'd0);

        // Flush at count 2 with a concurrent push of tag 9
        out_ready = 1'b0;
        drive_tagged(32'd7);
        tick();
        drive_tagged(32'd8);
        tick();
        drive_tagged(32'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {63'd0, out_valid64}, 64'd0);
        chk("fl_in_ready", {63'd0, in_ready64}, 64'd1);
        // Flush at count 1 where the push would otherwise be accepted
        drive_tagged(32'd7);
        tick();
        drive_tagged(32'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("fl1_valid", {63'd0, out_valid64}, 64'd0);
        tick();
        chk("fl1_still_empty", {63'd0, out_valid64}, 64'd0);
        drive_tagged(32'd10);
        tick();
        in_valid = 1'b0;
        chk("fl_after_tag", {32'd0, tag64}, 64'd10);
        chk("fl_after_valid", {63'd0, out_valid64}, 64'd1);

        // Reset mid-stream at count 2
        out_ready = 1'b0;
        drive_tagged(32'd11);
        tick();
        drive_tagged(32'd12);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", {63'd0, out_valid64}, 64'd0);
        chk("mrst_imm", imm64, 64'd0);
        chk("mrst_tag", {32'd0, tag64}, 64'd0);
        chk("mrst_in_ready", {63'd0, in_ready64}, 64'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        inst      = 32'h800000B7;
        sel       = 3'd5;
        in_tag    = 32'd13;
        tick();
        in_valid = 1'b0;
        chk("mrst_new_imm64", imm64, 64'hFFFFFFFF80000000);
        chk("mrst_new_imm32", {32'd0, imm32}, 64'h0000000080000000);
        chk("mrst_new_tag", {32'd0, tag64}, 64'd13);
        tick();
        chk("final_empty", {63'd0, out_valid64}, 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
